// File: rtl/argo_chan_reduce.sv
// Sums groups of COUNT words (or fewer on flush) and presents sum plus word count downstream.
// Result valid 1 cycle after the closing word; oready is low while a result is held and iready stalls it indefinitely.
module argo_chan_reduce #(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = 8,
    parameter int COUNT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ivalid,
    output logic                    oready,
    input  logic [WIDTH-1:0]        datain,
    input  logic                    flush,
    output logic                    ovalid,
    input  logic                    iready,
    output logic [WIDTH+CWIDTH-1:0] dataout,
    output logic [CWIDTH-1:0]       ocount
);

    localparam int SW = WIDTH + CWIDTH;

    localparam logic ACCUM = 1'b0;
    localparam logic HOLD  = 1'b1;

    logic              state;
    logic [SW-1:0]     acc;
    logic [SW-1:0]     acc_nxt;
    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] cnt_nxt;
    logic              in_xfer;
    logic              out_xfer;
    logic              close;

    // oready follows rst directly so it rises with deassertion, not a cycle later
    assign oready   = rst && (state == ACCUM);
    assign ovalid   = (state == HOLD);
    assign in_xfer  = ivalid && oready;
    assign out_xfer = ovalid && iready;

    assign acc_nxt = in_xfer ? acc + {{CWIDTH{1'b0}}, datain} : acc;
    assign cnt_nxt = in_xfer ? cnt + CWIDTH'(1) : cnt;

    // A flush with no held or arriving word would produce an empty group, so it is dropped
    assign close = (state == ACCUM) &&
                   ((in_xfer && (cnt_nxt == CWIDTH'(COUNT))) ||
                    (flush && ((cnt != '0) || in_xfer)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            dataout <= '0;
            ocount  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        state   <= HOLD;
                        dataout <= acc_nxt;
                        ocount  <= cnt_nxt;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    if (out_xfer) begin
                        state <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argo_chan_reduce.sv
module tb_argo_chan_reduce;

    localparam int C1 = 4;

    logic        clk;
    logic        rst;

    logic        ivalid, oready, flush, ovalid, iready;
    logic [31:0] datain;
    logic [39:0] dataout;
    logic [7:0]  ocount;

    logic        ivalid2, oready2, flush2, ovalid2, iready2;
    logic [31:0] datain2;
    logic [39:0] dataout2;
    logic [7:0]  ocount2;

    argo_chan_reduce #(.WIDTH(32), .CWIDTH(8), .COUNT(C1)) dut (
        .clk(clk), .rst(rst), .ivalid(ivalid), .oready(oready), .datain(datain),
        .flush(flush), .ovalid(ovalid), .iready(iready), .dataout(dataout), .ocount(ocount)
    );

    argo_chan_reduce #(.WIDTH(32), .CWIDTH(8), .COUNT(255)) dut255 (
        .clk(clk), .rst(rst), .ivalid(ivalid2), .oready(oready2), .datain(datain2),
        .flush(flush2), .ovalid(ovalid2), .iready(iready2), .dataout(dataout2), .ocount(ocount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [31:0] d, input logic f, input logic ir);
        ivalid = iv;
        datain = d;
        flush  = f;
        iready = ir;
        @(posedge clk);
        #1;
    endtask

    // {ovalid, oready, dataout, ocount}; payload only meaningful while a result is held
    function automatic logic [63:0] obs(input logic v, input logic r, input logic [39:0] d, input logic [7:0] c);
        return {14'd0, v, r, v ? d : 40'd0, v ? c : 8'd0};
    endfunction

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        f;
        logic        ir;
        logic        ev;
        logic        er;
        logic [39:0] ed;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic iv, input logic [31:0] d, input logic f, input logic ir,
                              input logic ev, input logic er, input logic [39:0] ed, input logic [7:0] ec);
        tbl.push_back(vec_t'{iv, d, f, ir, ev, er, ed, ec});
    endfunction

    // Reference model: the open group is a list of words; a closed group is its sum and length
    logic [31:0] m_words[$];
    logic        m_hold;
    logic [39:0] m_sum;
    logic [7:0]  m_cnt;

    function automatic void model_step(input logic iv, input logic [31:0] d, input logic f, input logic ir);
        if (m_hold) begin
            if (ir) m_hold = 1'b0;
        end else begin
            if (iv) m_words.push_back(d);
            if (m_words.size() == C1 || (f && m_words.size() > 0)) begin
                m_sum = '0;
                foreach (m_words[k]) m_sum = m_sum + 40'(m_words[k]);
                m_cnt  = 8'(m_words.size());
                m_hold = 1'b1;
                m_words.delete();
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        ivalid = 1'b0; flush = 1'b0; iready = 1'b0; datain = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_words.delete();
        m_hold = 1'b0;
        m_sum  = '0;
        m_cnt  = '0;
    endtask

    logic        r_iv, r_f, r_ir;
    logic [31:0] r_d;
    int          groups;

    initial begin
        rst = 1'b0;
        ivalid = 1'b1; datain = 32'h33; flush = 1'b0; iready = 1'b1;
        ivalid2 = 1'b0; datain2 = '0; flush2 = 1'b0; iready2 = 1'b1;

        // reset held with ivalid high: nothing accepted, outputs idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_outputs", obs(ovalid, oready, dataout, ocount) | {24'd0, dataout} | {56'd0, ocount},
                  64'd0);
        end
        rst = 1'b1;
        #1;
        check("oready_on_release", {63'd0, oready}, 64'd1);
        cyc(1'b1, 32'h33, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        check("first_accept_after_release", obs(ovalid, oready, dataout, ocount), obs(1'b1, 1'b0, 40'h33, 8'd1));
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        do_reset();

        // full group, back-to-back
        v(1, 32'h25, 0, 1, 0, 1, 0, 0);
        v(1, 32'h55, 0, 1, 0, 1, 0, 0);
        v(1, 32'h10, 0, 1, 0, 1, 0, 0);
        v(1, 32'h01, 0, 1, 1, 0, 40'h8B, 4);
        v(1, 32'h99, 0, 1, 0, 1, 0, 0);
        v(1, 32'h99, 0, 1, 0, 1, 0, 0);
        v(0, 32'h00, 1, 1, 1, 0, 40'h99, 1);
        v(0, 32'h00, 0, 1, 0, 1, 0, 0);
        // backpressure for 5 cycles with next word waiting
        v(1, 32'h25, 0, 1, 0, 1, 0, 0);
        v(1, 32'h55, 0, 1, 0, 1, 0, 0);
        v(1, 32'h10, 0, 1, 0, 1, 0, 0);
        v(1, 32'h01, 0, 0, 1, 0, 40'h8B, 4);
        for (int i = 0; i < 5; i++) v(1, 32'h99, 0, 0, 1, 0, 40'h8B, 4);
        v(1, 32'h99, 0, 1, 0, 1, 0, 0);
        v(1, 32'h99, 0, 1, 0, 1, 0, 0);
        v(0, 32'h00, 1, 1, 1, 0, 40'h99, 1);
        v(0, 32'h00, 0, 1, 0, 1, 0, 0);
        // early flush, then flush with nothing open
        v(1, 32'h25, 0, 1, 0, 1, 0, 0);
        v(1, 32'h55, 0, 1, 0, 1, 0, 0);
        v(0, 32'h00, 1, 1, 1, 0, 40'h7A, 2);
        v(0, 32'h00, 0, 1, 0, 1, 0, 0);
        v(0, 32'h00, 1, 1, 0, 1, 0, 0);
        v(0, 32'h00, 0, 1, 0, 1, 0, 0);
        // flush together with the closing word
        v(1, 32'd1, 0, 1, 0, 1, 0, 0);
        v(1, 32'd2, 0, 1, 0, 1, 0, 0);
        v(1, 32'd3, 0, 1, 0, 1, 0, 0);
        v(1, 32'd4, 1, 1, 1, 0, 40'd10, 4);
        v(0, 32'd0, 1, 1, 0, 1, 0, 0);
        v(0, 32'd0, 0, 1, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].f, tbl[i].ir);
            check($sformatf("vec%0d", i), obs(ovalid, oready, dataout, ocount),
                  obs(tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].ec));
        end

        // reset while a result is held: ovalid drops without a clock edge
        cyc(1, 32'd1, 0, 0);
        cyc(1, 32'd2, 0, 0);
        cyc(1, 32'd3, 0, 0);
        cyc(1, 32'd4, 0, 0);
        cyc(0, 32'd0, 0, 0);
        check("hold_before_reset", obs(ovalid, oready, dataout, ocount), obs(1'b1, 1'b0, 40'd10, 8'd4));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_in_hold", {62'd0, ovalid, oready} | {24'd0, dataout} | {56'd0, ocount}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // partial group discarded by reset
        cyc(1, 32'd7, 0, 1);
        cyc(1, 32'd7, 0, 1);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 32'd1, 0, 1);
        check("sum_from_zero_after_reset", obs(ovalid, oready, dataout, ocount), obs(1'b1, 1'b0, 40'd4, 8'd4));
        cyc(0, 32'd0, 0, 1);

        // COUNT=255 instance with all-ones words
        for (int i = 0; i < 255; i++) begin
            ivalid2 = 1'b1;
            datain2 = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            if (i == 253) check("c255_not_early", {63'd0, ovalid2}, 64'd0);
        end
        ivalid2 = 1'b0;
        check("c255_result", {23'd0, ovalid2, dataout2, ocount2}, {23'd0, 1'b1, 40'hFE_FFFF_FF01, 8'd255});
        @(posedge clk);
        #1;
        check("c255_drained", {63'd0, ovalid2}, 64'd0);

        // randomized traffic against the list-based model
        do_reset();
        r_iv = 1'b0; r_d = '0; r_f = 1'b0; r_ir = 1'b0;
        groups = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(m_hold && r_iv)) begin
                r_iv = ($urandom_range(0, 3) != 0);
                r_d  = $urandom;
            end
            r_f  = ($urandom_range(0, 7) == 0);
            r_ir = ($urandom_range(0, 3) != 0);
            if (m_hold && r_ir) groups++;
            model_step(r_iv, r_d, r_f, r_ir);
            cyc(r_iv, r_d, r_f, r_ir);
            check($sformatf("rand%0d", i), obs(ovalid, oready, dataout, ocount),
                  obs(m_hold, !m_hold, m_sum, m_cnt));
        end
        check("rand_groups_seen", {63'd0, groups > 100}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/argo_chan_reduce.md
# argo_chan_reduce

Downstream consumer stage for the argo 3-stage pipeline. Accepts 32-bit words over the codebase's valid/ready channel and sums groups of COUNT words (or fewer on `flush`). Presents each group sum with its word count on an identical valid/ready channel to the next stage. Models a reducing go-routine that reads a channel and forwards per-batch totals.

## Interface
- `WIDTH`, 32, input data width.
- `CWIDTH`, 8, group counter width; also width of `ocount`.
- `COUNT`, 4, words per group; legal range 1 .. 2^CWIDTH-1.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted when 0).
- `ivalid` in 1: upstream presents a word on `datain`.
- `oready` out 1: this block can accept a word this cycle.
- `datain` in WIDTH: input word, unsigned.
- `flush` in 1: close the current partial group early.
- `ovalid` out 1: group result valid on `dataout`/`ocount`.
- `iready` in 1: downstream accepts the result this cycle.
- `dataout` out WIDTH+CWIDTH: unsigned group sum.
- `ocount` out CWIDTH: number of words in the group.

## Operation
- Input transfer occurs on a rising edge where `ivalid && oready`; output transfer where `ovalid && iready`.
- Two states: ACCUM and HOLD.
- ACCUM: `oready`=1, `ovalid`=0. On input transfer: acc += zero-extended `datain`, cnt += 1.
- ACCUM -> HOLD when either condition holds:
  - the transfer makes cnt == COUNT;
  - `flush`=1 and (cnt > 0 or a transfer occurs this cycle).
- On entry to HOLD, `dataout` gets the final sum (including this edge's word) and `ocount` gets the final cnt. The accumulator and counter are then cleared.
- HOLD: `oready`=0, `ovalid`=1; `dataout`/`ocount` held stable until the output transfer. On the transfer: `ovalid`=0, return to ACCUM.
- `flush` is ignored in HOLD. `flush` in ACCUM with cnt==0 and no transfer is ignored: no empty groups are ever emitted.
- `flush` together with the COUNT-th word closes one group of COUNT; no extra group.
- Arithmetic:
  - sum width WIDTH+CWIDTH;
  - overflow is impossible for legal COUNT;
  - no saturation or wrap logic required.
- Upstream is expected to hold `datain`/`ivalid` while `oready`=0; the block never latches data while `oready`=0.

## Timing
- Reset (`rst`=0, asynchronous): state ACCUM; `oready`=0, `ovalid`=0, `dataout`=0, `ocount`=0; acc and cnt =0.
- `oready` is forced 0 while `rst`=0. It rises combinationally with deassertion, so it is 1 from the first edge after release.
- Reset asserted mid-group or in HOLD discards the partial sum or pending result immediately; there is no output transfer.
- Latency: `ovalid` rises the edge that accepts the closing word; result visible 1 cycle after the last input transfer.
- Throughput:
  - COUNT input transfers, then at least 1 HOLD cycle;
  - best case is COUNT+1 cycles per group with `iready` held 1.
- `iready` low stalls in HOLD indefinitely with outputs stable. `ovalid` never drops without a transfer.
- `oready` and `ovalid` are mutually exclusive in every cycle.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `ivalid`=1 -> `oready`=0, `ovalid`=0, `dataout`=0, `ocount`=0. After release, first accept on the following edge.
- Full group, COUNT=4, `iready`=1: stream 0x25, 0x55, 0x10, 0x01 back-to-back.
  - `ovalid` for exactly 1 cycle after the 4th word, with `dataout`=0x8B, `ocount`=4.
  - `oready`=0 that cycle; 5th word is accepted the next cycle.
- Backpressure: same stream, `iready`=0 for 5 cycles after `ovalid` rises.
  - `dataout`=0x8B, `ocount`=4 stable throughout; `oready`=0.
  - Word 0x99 held on `datain` is accepted only after the transfer, starting a new group.
- Flush: words 0x25, 0x55, then `flush` alone -> `dataout`=0x7A, `ocount`=2. Then `flush` with cnt==0 and no word -> no `ovalid`.
- Flush plus last word: words 1, 2, 3, then 4 with `flush`=1 -> exactly one result, `dataout`=10, `ocount`=4; no following empty group.
- Width/limit: COUNT=255, every word 0xFFFFFFFF -> `dataout`=0xFE_FFFFFF01, `ocount`=255, no truncation.
- Mid-operation reset: reset asserted during HOLD -> `ovalid` drops asynchronously. Next group after release sums from 0.
